// File: rtl/sc_init_pkg.sv
// Shared types for the front-end power-up configuration sequencer:
// FSM state encoding and the address/data pair held in the init table.
package sc_init_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ISSUE,
    WAIT_ACK,
    GAP,
    DONE,
    FAULT
  } seq_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } init_cmd_t;

endpackage

// File: rtl/init_cmd_rom.sv
// Combinational lookup of the front-end register init table.
// Indices past the populated entries read back as all-zero.
module init_cmd_rom
  import sc_init_pkg::*;
(
  input  logic [7:0] idx,
  output init_cmd_t  cmd
);

  // Order matters: the soft reset goes first, the enable goes last.
  always_comb begin
    cmd = '0;
    case (idx)
      8'd0:    cmd = '{addr: 8'h01, data: 16'h8001};
      8'd1:    cmd = '{addr: 8'h02, data: 16'h0040};
      8'd2:    cmd = '{addr: 8'h10, data: 16'h1234};
      8'd3:    cmd = '{addr: 8'h11, data: 16'h00FF};
      8'd4:    cmd = '{addr: 8'h20, data: 16'h0003};
      8'd5:    cmd = '{addr: 8'h21, data: 16'hA5A5};
      8'd6:    cmd = '{addr: 8'h30, data: 16'h0001};
      8'd7:    cmd = '{addr: 8'h3F, data: 16'h0100};
      default: cmd = '0;
    endcase
  end

endmodule

// File: rtl/init_sequencer.sv
// Power-up configuration sequencer: settles after reset, then walks the init
// table over a valid/ready command port with per-write ack, timeout and retry.
module init_sequencer
  import sc_init_pkg::*;
#(
  parameter int CLK_PER_MS  = 54000,
  parameter int SETTLE_MS   = 10,
  parameter int N_CMDS      = 8,
  parameter int GAP_CYC     = 16,
  parameter int ACK_TIMEOUT = 1024,
  parameter int MAX_RETRY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_data,
  input  logic              ack,
  input  logic              ack_err,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [7:0]        fault_idx,
  output logic [7:0]        retry_total
);

  localparam int SETTLE_CYC = SETTLE_MS * CLK_PER_MS;
  localparam int SET_W      = $clog2(SETTLE_CYC + 1);
  localparam int TMR_MAX    = (ACK_TIMEOUT > GAP_CYC) ? ACK_TIMEOUT : GAP_CYC;
  localparam int TMR_W      = $clog2(TMR_MAX + 1);

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] ACK_LAST    = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GAP_LAST    = TMR_W'(GAP_CYC - 1);
  localparam logic [7:0]       LAST_IDX    = 8'(N_CMDS - 1);
  localparam logic [7:0]       RETRY_MAX   = 8'(MAX_RETRY);

  seq_state_t       state, state_n;
  logic [SET_W-1:0] settle_cnt, settle_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [7:0]       idx, idx_n;
  logic [7:0]       retry_cnt, retry_n;
  logic [7:0]       retry_total_n, fault_idx_n;
  logic             advance, advance_n;
  init_cmd_t        rom_cmd;

  // Looked up with the next index so addr/data register in step with cmd_valid.
  init_cmd_rom u_rom (
    .idx (idx_n),
    .cmd (rom_cmd)
  );

  always_comb begin
    state_n       = state;
    settle_n      = settle_cnt;
    timer_n       = timer;
    idx_n         = idx;
    retry_n       = retry_cnt;
    advance_n     = advance;
    retry_total_n = retry_total;
    fault_idx_n   = fault_idx;

    unique case (state)
      IDLE: begin
        state_n  = SETTLE;
        settle_n = '0;
      end
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) state_n = ISSUE;
        else                           settle_n = settle_cnt + 1'b1;
      end
      ISSUE: begin
        if (cmd_valid && cmd_ready) begin
          state_n = WAIT_ACK;
          timer_n = '0;
        end
      end
      WAIT_ACK: begin
        if (ack && !ack_err) begin
          state_n   = GAP;
          timer_n   = '0;
          retry_n   = '0;
          advance_n = 1'b1;
        end else if (ack || timer == ACK_LAST) begin
          if (retry_cnt < RETRY_MAX) begin
            state_n       = GAP;
            timer_n       = '0;
            retry_n       = retry_cnt + 8'd1;
            advance_n     = 1'b0;
            retry_total_n = (retry_total == 8'hFF) ? retry_total : retry_total + 8'd1;
          end else begin
            state_n     = FAULT;
            fault_idx_n = idx;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      GAP: begin
        if (timer == GAP_LAST) begin
          if (!advance)             state_n = ISSUE;
          else if (idx == LAST_IDX) state_n = DONE;
          else begin
            state_n = ISSUE;
            idx_n   = idx + 8'd1;
          end
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      DONE:    state_n = DONE;
      FAULT:   state_n = FAULT;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      timer       <= '0;
      idx         <= '0;
      retry_cnt   <= '0;
      advance     <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_addr    <= '0;
      cmd_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= 1'b0;
      fault_idx   <= '0;
      retry_total <= '0;
    end else begin
      state       <= state_n;
      settle_cnt  <= settle_n;
      timer       <= timer_n;
      idx         <= idx_n;
      retry_cnt   <= retry_n;
      advance     <= advance_n;
      cmd_valid   <= (state_n == ISSUE);
      cmd_addr    <= rom_cmd.addr;
      cmd_data    <= rom_cmd.data;
      busy        <= (state_n == SETTLE) || (state_n == ISSUE) ||
                     (state_n == WAIT_ACK) || (state_n == GAP);
      done        <= (state_n == DONE);
      fault       <= (state_n == FAULT);
      fault_idx   <= fault_idx_n;
      retry_total <= retry_total_n;
    end
  end

endmodule

// File: tb/tb_init_sequencer.sv
// Directed bench for init_sequencer with a short settle time and a three-entry table.
module tb_init_sequencer;
  import sc_init_pkg::*;

  localparam int CLK_PER_MS  = 10;
  localparam int SETTLE_MS   = 2;
  localparam int N_CMDS      = 3;
  localparam int GAP_CYC     = 4;
  localparam int ACK_TIMEOUT = 8;
  localparam int MAX_RETRY   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_ready = 1'b0;
  logic              ack = 1'b0;
  logic              ack_err = 1'b0;
  logic              cmd_valid;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              busy, done, fault;
  logic [7:0]        fault_idx, retry_total;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_addr [3] = '{8'h01, 8'h02, 8'h10};
  logic [15:0] exp_data [3] = '{16'h8001, 16'h0040, 16'h1234};

  init_sequencer #(
    .CLK_PER_MS (CLK_PER_MS),
    .SETTLE_MS  (SETTLE_MS),
    .N_CMDS     (N_CMDS),
    .GAP_CYC    (GAP_CYC),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_data   (cmd_data),
    .ack        (ack),
    .ack_err    (ack_err),
    .busy       (busy),
    .done       (done),
    .fault      (fault),
    .fault_idx  (fault_idx),
    .retry_total(retry_total)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One clock, observed 1 time unit after the edge; ack is a single-cycle pulse.
  task automatic step();
    @(posedge clk);
    #1;
    ack     = 1'b0;
    ack_err = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_ready = 1'b0; ack = 1'b0; ack_err = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cnt, output bit ok);
    cnt = 0;
    ok  = 1'b0;
    while (!ok && cnt < limit) begin
      step();
      cnt++;
      ok = cmd_valid;
    end
  endtask

  // Handshake the currently valid command, then raise ack for the next edge.
  task automatic hs_ack(input logic err);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    step();
    ack     = 1'b1;
    ack_err = err;
  endtask

  task automatic run_clean(input int from);
    int c;
    bit ok;
    for (int i = from; i < N_CMDS; i++) begin
      wait_valid(60, c, ok);
      if (!ok) return;
      hs_ack(1'b0);
    end
    repeat (6) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_cmd_valid: got %b expected 0", cmd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0 || fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_done_fault: got %b/%b expected 0/0", done, fault); end
    checks++; if (cmd_addr !== 8'h00 || cmd_data !== 16'h0000) begin errors++; $display("[TB] FAIL reset_addr_data: got %h/%h expected 00/0000", cmd_addr, cmd_data); end
    checks++; if (fault_idx !== 8'd0 || retry_total !== 8'd0) begin errors++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", fault_idx, retry_total); end
  endtask

  task automatic test_nominal();
    int c;
    bit ok;
    do_reset();
    wait_valid(60, c, ok);
    checks++; if (!ok || c != 21) begin errors++; $display("[TB] FAIL first_valid_latency: got %0d cycles expected 21", c); end
    for (int i = 0; i < N_CMDS; i++) begin
      if (i > 0) begin
        wait_valid(30, c, ok);
        checks++; if (!ok || c != GAP_CYC + 1) begin errors++; $display("[TB] FAIL valid_spacing_%0d: got %0d expected %0d", i, c, GAP_CYC + 1); end
      end
      checks++; if (cmd_addr !== exp_addr[i] || cmd_data !== exp_data[i]) begin errors++; $display("[TB] FAIL entry_%0d_addr_data: got %h/%h expected %h/%h", i, cmd_addr, cmd_data, exp_addr[i], exp_data[i]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL entry_%0d_busy: got %b expected 1", i, busy); end
      hs_ack(1'b0);
    end
    repeat (6) step();
    checks++; if (done !== 1'b1 || fault !== 1'b0) begin errors++; $display("[TB] FAIL nominal_done: got done=%b fault=%b expected 1/0", done, fault); end
    checks++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL nominal_idle_outputs: got busy=%b valid=%b expected 0/0", busy, cmd_valid); end
    checks++; if (retry_total !== 8'd0) begin errors++; $display("[TB] FAIL nominal_retry_total: got %0d expected 0", retry_total); end
  endtask

  task automatic test_ready_stall();
    int c;
    bit ok;
    do_reset();
    wait_valid(60, c, ok);
    for (int k = 0; k < 50; k++) begin
      step();
      checks++;
      if (cmd_valid !== 1'b1 || cmd_addr !== exp_addr[0] || cmd_data !== exp_data[0]) begin
        errors++;
        $display("[TB] FAIL stall_hold_%0d: got valid=%b %h/%h expected 1 %h/%h", k, cmd_valid, cmd_addr, cmd_data, exp_addr[0], exp_data[0]);
      end
    end
    checks++; if (retry_total !== 8'd0 || fault !== 1'b0) begin errors++; $display("[TB] FAIL stall_no_timeout: got retries=%0d fault=%b expected 0/0", retry_total, fault); end
    hs_ack(1'b0);
    run_clean(1);
    checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL stall_done: got %b expected 1", done); end
  endtask

  task automatic test_retry();
    int c;
    bit ok;
    do_reset();
    wait_valid(60, c, ok);
    hs_ack(1'b0);
    wait_valid(30, c, ok);
    checks++; if (cmd_addr !== exp_addr[1]) begin errors++; $display("[TB] FAIL retry_entry1_addr: got %h expected %h", cmd_addr, exp_addr[1]); end
    hs_ack(1'b1);
    wait_valid(30, c, ok);
    checks++; if (!ok || c != GAP_CYC + 1) begin errors++; $display("[TB] FAIL retry_reissue_spacing: got %0d expected %0d", c, GAP_CYC + 1); end
    checks++; if (cmd_addr !== exp_addr[1] || cmd_data !== exp_data[1]) begin errors++; $display("[TB] FAIL retry_reissue_entry: got %h/%h expected %h/%h", cmd_addr, cmd_data, exp_addr[1], exp_data[1]); end
    checks++; if (retry_total !== 8'd1) begin errors++; $display("[TB] FAIL retry_count_after_err: got %0d expected 1", retry_total); end
    hs_ack(1'b0);
    wait_valid(30, c, ok);
    checks++; if (cmd_addr !== exp_addr[2]) begin errors++; $display("[TB] FAIL retry_entry2_addr: got %h expected %h", cmd_addr, exp_addr[2]); end
    hs_ack(1'b0);
    repeat (6) step();
    checks++; if (done !== 1'b1 || fault !== 1'b0 || retry_total !== 8'd1) begin errors++; $display("[TB] FAIL retry_final: got done=%b fault=%b retries=%0d expected 1/0/1", done, fault, retry_total); end
  endtask

  task automatic test_timeout_fault();
    int c;
    bit ok;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      wait_valid(60, c, ok);
      hs_ack(1'b0);
    end
    for (int a = 0; a <= MAX_RETRY; a++) begin
      wait_valid(30, c, ok);
      if (a > 0) begin
        checks++; if (!ok || c != GAP_CYC) begin errors++; $display("[TB] FAIL timeout_reissue_%0d: got %0d expected %0d", a, c, GAP_CYC); end
      end
      checks++; if (cmd_addr !== exp_addr[2]) begin errors++; $display("[TB] FAIL timeout_attempt_%0d_addr: got %h expected %h", a, cmd_addr, exp_addr[2]); end
      cmd_ready = 1'b1;
      step();
      cmd_ready = 1'b0;
      repeat (ACK_TIMEOUT - 1) step();
      checks++; if (retry_total !== 8'(a) || fault !== 1'b0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL timeout_early_%0d: got retries=%0d fault=%b busy=%b expected %0d/0/1", a, retry_total, fault, busy, a); end
      step();
      if (a < MAX_RETRY) begin
        checks++; if (retry_total !== 8'(a + 1) || fault !== 1'b0) begin errors++; $display("[TB] FAIL timeout_retry_%0d: got retries=%0d fault=%b expected %0d/0", a, retry_total, fault, a + 1); end
      end else begin
        checks++; if (fault !== 1'b1 || done !== 1'b0) begin errors++; $display("[TB] FAIL fault_flags: got fault=%b done=%b expected 1/0", fault, done); end
        checks++; if (fault_idx !== 8'd2 || retry_total !== 8'd2) begin errors++; $display("[TB] FAIL fault_idx_retries: got %0d/%0d expected 2/2", fault_idx, retry_total); end
        checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL fault_outputs: got valid=%b busy=%b expected 0/0", cmd_valid, busy); end
      end
    end
    repeat (10) step();
    checks++; if (fault !== 1'b1 || cmd_valid !== 1'b0) begin errors++; $display("[TB] FAIL fault_terminal: got fault=%b valid=%b expected 1/0", fault, cmd_valid); end
  endtask

  task automatic test_reset_abort();
    int c;
    bit ok;
    do_reset();
    wait_valid(60, c, ok);
    hs_ack(1'b0);
    wait_valid(30, c, ok);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    step();
    rst = 1'b1;
    ack = 1'b1;
    step();
    checks++; if (cmd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin errors++; $display("[TB] FAIL abort_flags: got valid=%b busy=%b done=%b fault=%b expected 0000", cmd_valid, busy, done, fault); end
    checks++; if (cmd_addr !== 8'h00 || cmd_data !== 16'h0000 || fault_idx !== 8'd0 || retry_total !== 8'd0) begin errors++; $display("[TB] FAIL abort_values: got %h/%h idx=%0d retries=%0d expected all 0", cmd_addr, cmd_data, fault_idx, retry_total); end
    rst = 1'b0;
    ack = 1'b1;
    wait_valid(60, c, ok);
    checks++; if (!ok || c != 21) begin errors++; $display("[TB] FAIL abort_restart_latency: got %0d expected 21", c); end
    checks++; if (cmd_addr !== exp_addr[0] || cmd_data !== exp_data[0]) begin errors++; $display("[TB] FAIL abort_restart_entry: got %h/%h expected %h/%h", cmd_addr, cmd_data, exp_addr[0], exp_data[0]); end
    run_clean(0);
    checks++; if (done !== 1'b1 || retry_total !== 8'd0) begin errors++; $display("[TB] FAIL abort_done: got done=%b retries=%0d expected 1/0", done, retry_total); end
  endtask

  task automatic test_spurious_ack();
    int c;
    do_reset();
    for (int k = 1; k <= 21; k++) begin
      ack     = 1'b1;
      ack_err = (k % 2 == 1);
      step();
      checks++;
      if (cmd_valid !== (k == 21)) begin
        errors++;
        $display("[TB] FAIL settle_ack_%0d: got valid=%b expected %b", k, cmd_valid, (k == 21));
      end
    end
    hs_ack(1'b0);
    step();
    c = 1;
    while (!cmd_valid && c < 20) begin
      ack     = 1'b1;
      ack_err = 1'b1;
      step();
      c++;
    end
    checks++; if (c != GAP_CYC + 1) begin errors++; $display("[TB] FAIL gap_ack_spacing: got %0d expected %0d", c, GAP_CYC + 1); end
    checks++; if (cmd_addr !== exp_addr[1] || retry_total !== 8'd0) begin errors++; $display("[TB] FAIL gap_ack_ignored: got addr=%h retries=%0d expected %h/0", cmd_addr, retry_total, exp_addr[1]); end
    run_clean(1);
    checks++; if (done !== 1'b1 || retry_total !== 8'd0) begin errors++; $display("[TB] FAIL spurious_done: got done=%b retries=%0d expected 1/0", done, retry_total); end
  endtask

  initial begin
    $display("[TB] init_sequencer directed tests starting");
    test_reset();
    test_nominal();
    test_ready_stall();
    test_retry();
    test_timeout_fault();
    test_reset_abort();
    test_spurious_ack();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
